// File: rtl/id_ex_operand_stage.sv
// ID/EX register with forwarding and load-use bubble; ID to EX in 1 cycle, stall_i holds EX and
// refreshes operand data, flush_i squashes. Define ID_EX_FORWARD_EN for EX/MEM and MEM/WB forwarding.
module id_ex_operand_stage #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [RADDR_W-1:0] id_rs_addr,
  input  logic [RADDR_W-1:0] id_rt_addr,
  input  logic [RADDR_W-1:0] id_rd_addr,
  input  logic [DATA_W-1:0]  id_rs_data,
  input  logic [DATA_W-1:0]  id_rt_data,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic [4:0]         id_shamt,
  input  logic [ALUOP_W-1:0] id_alu_op,
  input  logic               id_src1_shamt,
  input  logic               id_src2_imm,
  input  logic               id_reg_write,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic               exm_reg_write,
  input  logic               exm_mem_read,
  input  logic [RADDR_W-1:0] exm_rd,
  input  logic [DATA_W-1:0]  exm_result,
  input  logic               mwb_reg_write,
  input  logic [RADDR_W-1:0] mwb_rd,
  input  logic [DATA_W-1:0]  mwb_data,
  output logic               load_use_stall,
  output logic [DATA_W-1:0]  alu_in1,
  output logic [DATA_W-1:0]  alu_in2,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [DATA_W-1:0]  ex_store_data,
  output logic               ex_valid,
  output logic [RADDR_W-1:0] ex_rd,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               ex_mem_write
);

  typedef struct packed {
    logic               valid;
    logic [RADDR_W-1:0] rs;
    logic [RADDR_W-1:0] rt;
    logic [RADDR_W-1:0] rd;
    logic [DATA_W-1:0]  rs_data;
    logic [DATA_W-1:0]  rt_data;
    logic [DATA_W-1:0]  imm;
    logic [4:0]         shamt;
    logic [ALUOP_W-1:0] alu_op;
    logic               src1_shamt;
    logic               src2_imm;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
  } ex_slot_t;

  ex_slot_t          ex_q;
  ex_slot_t          id_slot;
  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;
  logic              ex_load_hit;

  always_comb begin
    id_slot            = '0;
    id_slot.valid      = id_valid;
    id_slot.rs         = id_rs_addr;
    id_slot.rt         = id_rt_addr;
    id_slot.rd         = id_rd_addr;
    id_slot.rs_data    = id_rs_data;
    id_slot.rt_data    = id_rt_data;
    id_slot.imm        = id_imm;
    id_slot.shamt      = id_shamt;
    id_slot.alu_op     = id_alu_op;
    id_slot.src1_shamt = id_src1_shamt;
    id_slot.src2_imm   = id_src2_imm;
    id_slot.reg_write  = id_reg_write;
    id_slot.mem_read   = id_mem_read;
    id_slot.mem_write  = id_mem_write;
  end

  assign ex_load_hit = id_valid & ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) &
                       ((ex_q.rd == id_rs_addr) | (ex_q.rd == id_rt_addr));

`ifdef ID_EX_FORWARD_EN
  // EX/MEM loads have no data yet, so only ALU results are forwarded from that stage.
  always_comb begin
    fwd_rs = ex_q.rs_data;
    if (exm_reg_write && !exm_mem_read && (exm_rd != '0) && (exm_rd == ex_q.rs))
      fwd_rs = exm_result;
    else if (mwb_reg_write && (mwb_rd != '0) && (mwb_rd == ex_q.rs))
      fwd_rs = mwb_data;
  end

  always_comb begin
    fwd_rt = ex_q.rt_data;
    if (exm_reg_write && !exm_mem_read && (exm_rd != '0) && (exm_rd == ex_q.rt))
      fwd_rt = exm_result;
    else if (mwb_reg_write && (mwb_rd != '0) && (mwb_rd == ex_q.rt))
      fwd_rt = mwb_data;
  end

  assign load_use_stall = ex_load_hit;
`else
  logic ex_raw_hit;
  logic exm_raw_hit;
  logic unused_fwd_inputs;

  assign fwd_rs = ex_q.rs_data;
  assign fwd_rt = ex_q.rt_data;

  // Without bypass paths, any pending writer in EX or EX/MEM must drain first.
  assign ex_raw_hit  = ex_q.valid & ex_q.reg_write & (ex_q.rd != '0) &
                       ((ex_q.rd == id_rs_addr) | (ex_q.rd == id_rt_addr));
  assign exm_raw_hit = exm_reg_write & (exm_rd != '0) &
                       ((exm_rd == id_rs_addr) | (exm_rd == id_rt_addr));

  assign load_use_stall = ex_load_hit | (id_valid & (ex_raw_hit | exm_raw_hit));

  assign unused_fwd_inputs = ^{exm_mem_read, exm_result, mwb_reg_write, mwb_rd, mwb_data,
                               ex_q.rs, ex_q.rt};
`endif

  // A held slot keeps capturing forwarded data so a producer retiring from WB is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
    end else if (flush_i) begin
      ex_q <= '0;
    end else if (stall_i) begin
      ex_q.rs_data <= fwd_rs;
      ex_q.rt_data <= fwd_rt;
    end else if (load_use_stall) begin
      ex_q <= '0;
    end else begin
      ex_q <= id_slot;
    end
  end

  assign alu_in1       = ex_q.src1_shamt ? {{(DATA_W-5){1'b0}}, ex_q.shamt} : fwd_rs;
  assign alu_in2       = ex_q.src2_imm ? ex_q.imm : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign alu_op        = ex_q.alu_op;
  assign ex_valid      = ex_q.valid;
  assign ex_rd         = ex_q.rd;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage; expectations follow the ID_EX_FORWARD_EN setting.
module tb_id_ex_operand_stage;

`ifdef ID_EX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_shamt;
  logic [3:0]  id_alu_op;
  logic        id_src1_shamt, id_src2_imm, id_reg_write, id_mem_read, id_mem_write;
  logic        stall_i, flush_i;
  logic        exm_reg_write, exm_mem_read;
  logic [4:0]  exm_rd;
  logic [31:0] exm_result;
  logic        mwb_reg_write;
  logic [4:0]  mwb_rd;
  logic [31:0] mwb_data;
  logic        load_use_stall;
  logic [31:0] alu_in1, alu_in2, ex_store_data;
  logic [3:0]  alu_op;
  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;

  int checks = 0;
  int errors = 0;

  id_ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_shamt(id_shamt), .id_alu_op(id_alu_op),
    .id_src1_shamt(id_src1_shamt), .id_src2_imm(id_src2_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .stall_i(stall_i), .flush_i(flush_i),
    .exm_reg_write(exm_reg_write), .exm_mem_read(exm_mem_read),
    .exm_rd(exm_rd), .exm_result(exm_result),
    .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
    .load_use_stall(load_use_stall), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_op(alu_op), .ex_store_data(ex_store_data), .ex_valid(ex_valid),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_rs_addr = 0; id_rt_addr = 0; id_rd_addr = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_shamt = 0; id_alu_op = 0;
    id_src1_shamt = 0; id_src2_imm = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    stall_i = 0; flush_i = 0;
    exm_reg_write = 0; exm_mem_read = 0; exm_rd = 0; exm_result = 0;
    mwb_reg_write = 0; mwb_rd = 0; mwb_data = 0;
  endtask

  task automatic id_alu(input logic [4:0] rs, input logic [31:0] rs_d, input logic [4:0] rt,
                        input logic [31:0] rt_d, input logic [4:0] rd, input logic [3:0] op);
    id_valid = 1; id_rs_addr = rs; id_rs_data = rs_d; id_rt_addr = rt; id_rt_data = rt_d;
    id_rd_addr = rd; id_alu_op = op; id_reg_write = 1; id_mem_read = 0; id_mem_write = 0;
    id_src1_shamt = 0; id_src2_imm = 0;
  endtask

  initial begin
    clear_inputs();
    rst_n = 0;
    #12;
    check("rst_ex_valid", ex_valid, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_ex_rd", ex_rd, 0);
    check("rst_alu_in1", alu_in1, 0);
    rst_n = 1;
    tick();

    // EX/MEM forward and EX/MEM-over-MEM/WB priority
    id_alu(5'd3, 32'h99, 5'd0, 32'h0, 5'd4, 4'd2);
    tick();
    check("ld_ex_valid", ex_valid, 1);
    check("ld_ex_rd", ex_rd, 4);
    check("ld_alu_op", alu_op, 2);
    clear_inputs();
    exm_reg_write = 1; exm_rd = 3; exm_result = 32'h11;
    #1;
    check("exm_fwd_in1", alu_in1, FWD ? 32'h11 : 32'h99);
    mwb_reg_write = 1; mwb_rd = 3; mwb_data = 32'h22;
    #1;
    check("exm_over_mwb", alu_in1, FWD ? 32'h11 : 32'h99);
    exm_mem_read = 1;
    #1;
    check("exm_load_no_fwd", alu_in1, FWD ? 32'h22 : 32'h99);
    exm_reg_write = 0; exm_mem_read = 0;
    #1;
    check("mwb_fwd_in1", alu_in1, FWD ? 32'h22 : 32'h99);
    tick();

    // Register 0 is never forwarded
    clear_inputs();
    id_alu(5'd0, 32'h0, 5'd0, 32'h0, 5'd1, 4'd0);
    exm_reg_write = 1; exm_rd = 0; exm_result = 32'h55;
    mwb_reg_write = 1; mwb_rd = 0; mwb_data = 32'h66;
    #1;
    check("r0_no_stall", load_use_stall, 0);
    tick();
    check("r0_in1", alu_in1, 0);
    check("r0_in2", alu_in2, 0);

    // Operand mux: shamt / immediate / store data
    clear_inputs();
    id_alu(5'd2, 32'h10, 5'd6, 32'h77, 5'd1, 4'd3);
    id_src1_shamt = 1; id_shamt = 5'd5; id_src2_imm = 1; id_imm = 32'h1234;
    tick();
    clear_inputs();
    #1;
    check("shamt_in1", alu_in1, 32'h5);
    check("imm_in2", alu_in2, 32'h1234);
    check("store_data", ex_store_data, 32'h77);
    tick();

    // Load-use hazard
    clear_inputs();
    id_alu(5'd1, 32'h0, 5'd0, 32'h0, 5'd5, 4'd0);
    id_mem_read = 1;
    tick();
    check("lw_ex_mem_read", ex_mem_read, 1);
    id_alu(5'd5, 32'h0, 5'd0, 32'h0, 5'd6, 4'd0);
    #1;
    check("lu_stall", load_use_stall, 1);
    tick();
    check("lu_bubble_valid", ex_valid, 0);
    check("lu_bubble_rw", ex_reg_write, 0);
    check("lu_bubble_rd", ex_rd, 0);
    exm_reg_write = 1; exm_mem_read = 1; exm_rd = 5; exm_result = 32'hDEAD;
    #1;
    check("lu_exm_stage", load_use_stall, FWD ? 0 : 1);
    tick();
    exm_reg_write = 0; exm_mem_read = 0; exm_rd = 0;
    mwb_reg_write = 1; mwb_rd = 5; mwb_data = 32'h5A5A;
    #1;
    check("lu_mwb_stage", load_use_stall, 0);
    tick();
    check("lu_add_valid", ex_valid, 1);
    check("lu_add_rd", ex_rd, 6);
    check("lu_add_in1", alu_in1, FWD ? 32'h5A5A : 32'h0);

    // Stall refresh across three hold cycles
    clear_inputs();
    id_alu(5'd7, 32'h1, 5'd0, 32'h0, 5'd8, 4'd1);
    tick();
    id_alu(5'd2, 32'h2, 5'd0, 32'h0, 5'd9, 4'd5);
    stall_i = 1;
    mwb_reg_write = 1; mwb_rd = 7; mwb_data = 32'hABCD;
    #1;
    check("stall_fwd_in1", alu_in1, FWD ? 32'hABCD : 32'h1);
    tick();
    mwb_reg_write = 0; mwb_rd = 0; mwb_data = 0;
    tick();
    tick();
    check("stall_hold_rd", ex_rd, 8);
    check("stall_hold_op", alu_op, 1);
    check("stall_refresh_in1", alu_in1, FWD ? 32'hABCD : 32'h1);
    stall_i = 0;
    tick();
    check("release_rd", ex_rd, 9);

    // Flush beats stall on the same edge
    id_alu(5'd2, 32'h2, 5'd0, 32'h0, 5'd11, 4'd5);
    flush_i = 1; stall_i = 1;
    tick();
    check("flush_valid", ex_valid, 0);
    check("flush_rw", ex_reg_write, 0);
    check("flush_rd", ex_rd, 0);

    // RAW against a non-load writer in EX
    clear_inputs();
    id_alu(5'd1, 32'h0, 5'd0, 32'h0, 5'd10, 4'd0);
    tick();
    id_alu(5'd0, 32'h0, 5'd10, 32'h0, 5'd12, 4'd0);
    #1;
    check("raw_ex_stall", load_use_stall, FWD ? 0 : 1);
    id_valid = 0;
    #1;
    check("raw_idle_nostall", load_use_stall, 0);

    // Asynchronous reset mid-run
    clear_inputs();
    id_alu(5'd1, 32'h3, 5'd2, 32'h4, 5'd13, 4'd7);
    id_mem_write = 1;
    tick();
    check("pre_rst_valid", ex_valid, 1);
    rst_n = 0;
    #1;
    check("arst_valid", ex_valid, 0);
    check("arst_op", alu_op, 0);
    check("arst_rd", ex_rd, 0);
    check("arst_mem_write", ex_mem_write, 0);
    #2;
    rst_n = 1;
    clear_inputs();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
